line_render_sequencer: RTL and testbench
========================================

LINE_RENDER_SEQUENCER -- requirements
Module: line_render_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports line_render_start  input  1 (one-cycle render request) and line_idx  input  9 (line to render).
REQ-004 SHALL have ports layer0_enabled, layer1_enabled, sprites_enabled  input  1 each  unit enables.
REQ-005 SHALL have ports layer0_done, layer1_done, sprite_done  input  1 each  one-cycle completion pulses from the renderers.
REQ-006 SHALL have ports display_next_line and display_next_frame  input  1 each  display timing strobes.
REQ-007 SHALL have ports layer0_start, layer1_start, sprite_start  output  1 each  one-cycle unit start pulses.
REQ-008 SHALL have port render_line_idx  output  9  latched line index for the renderers.
REQ-009 SHALL have ports lb_wrsel and lb_rdsel  output  1 each  line-buffer bank written by renderers / read by composer; lb_wrsel SHALL always equal !lb_rdsel.
REQ-010 SHALL have ports busy  output  1 (state not IDLE/DONE) and overrun  output  1 (one-cycle miss pulse).

Function
REQ-011 SHALL implement states IDLE, L0, L1, SPR, DONE; units share the VRAM bus, so they run serially: L0 -> L1 -> SPR.
REQ-012 In IDLE, on line_render_start, SHALL latch line_idx into render_line_idx and enter the first enabled unit state in order L0, L1, SPR; with none enabled, SHALL enter DONE directly.
REQ-013 On entering a unit state, SHALL assert that unit's start pulse for exactly the first cycle in the state (registered output, one cycle after the transition edge).
REQ-014 In a unit state, on that unit's done pulse, SHALL move to the next enabled unit state, or DONE if none remain; done pulses from other units SHALL be ignored.
REQ-015 Enables SHALL be sampled when deciding each transition, not latched at start.
REQ-016 On display_next_line in DONE, SHALL toggle lb_rdsel (lb_wrsel follows) and return to IDLE.
REQ-017 On display_next_line in L0, L1 or SPR, SHALL pulse overrun for one cycle, SHALL NOT swap, and SHALL continue the current line.
REQ-018 A done pulse coinciding with display_next_line in the last unit state SHALL count as a miss: overrun pulses and the state enters DONE; the swap occurs on the following display_next_line.
REQ-019 On display_next_line in IDLE, SHALL do nothing: no swap, no overrun.
REQ-020 On line_render_start while not IDLE, SHALL pulse overrun and ignore the request. The exception is REQ-021.
REQ-021 On display_next_line and line_render_start in the same cycle while in DONE, SHALL perform the swap and the start in the same edge, entering the first unit state.
REQ-022 On display_next_frame, SHALL return to IDLE from any state, with no start pulses, no swap and no overrun; display_next_frame SHALL take priority over all other events in that cycle.

Reset
REQ-023 On rst_n low, SHALL force IDLE, render_line_idx=0, lb_rdsel=0, lb_wrsel=1, and all start pulses, busy and overrun to 0, asynchronously, including mid-line.
REQ-024 After rst_n deasserts, SHALL accept line_render_start on the first clock edge.

Configuration
REQ-025 With macro LINE_RENDER_OVERRUN_COUNT_EN defined, SHALL add output overrun_count  8  saturating at 255, incremented on each overrun pulse, cleared by reset and by display_next_frame.
REQ-026 Without the macro, the overrun_count port and counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-027 All units enabled, line_render_start with line_idx=37, done pulses 20 cycles apart -> start pulses L0, L1, SPR in order; render_line_idx=37; busy high until the SPR done; next display_next_line toggles lb_rdsel 0->1.
REQ-028 Only sprites enabled, start with line_idx=5 -> only sprite_start pulses; after sprite_done, display_next_line -> lb_rdsel toggles.
REQ-029 All units disabled, line_render_start -> DONE the next cycle with no start pulses; display_next_line -> swap.
REQ-030 display_next_line while in L1 -> one overrun pulse, no swap; the line completes and the next display_next_line swaps; with the macro defined, overrun_count=1.
REQ-031 line_render_start in DONE coincident with display_next_line -> swap and L0 start on the same edge; line_render_start in SPR -> overrun, request ignored.
REQ-032 rst_n asserted in SPR, and separately display_next_frame in L0 -> IDLE; for reset, lb_rdsel=0; for display_next_frame, no start pulse, no overrun, lb_rdsel unchanged; 300 overruns with the macro defined -> overrun_count=255.

Source files
------------

// File: rtl/line_render_sequencer_if.sv
// Renderer-sequencer bus: render request, unit enables/handshakes,
// display timing strobes and line-buffer bank selects.
// Optional LINE_RENDER_OVERRUN_COUNT_EN adds the overrun_count signal.
interface line_render_sequencer_if;
  logic       line_render_start;
  logic [8:0] line_idx;
  logic       layer0_enabled;
  logic       layer1_enabled;
  logic       sprites_enabled;
  logic       layer0_done;
  logic       layer1_done;
  logic       sprite_done;
  logic       display_next_line;
  logic       display_next_frame;
  logic       layer0_start;
  logic       layer1_start;
  logic       sprite_start;
  logic [8:0] render_line_idx;
  logic       lb_wrsel;
  logic       lb_rdsel;
  logic       busy;
  logic       overrun;
`ifdef LINE_RENDER_OVERRUN_COUNT_EN
  logic [7:0] overrun_count;
`endif

  modport master (
    output line_render_start, line_idx,
    output layer0_enabled, layer1_enabled, sprites_enabled,
    output layer0_done, layer1_done, sprite_done,
    output display_next_line, display_next_frame,
    input  layer0_start, layer1_start, sprite_start,
    input  render_line_idx, lb_wrsel, lb_rdsel, busy, overrun
`ifdef LINE_RENDER_OVERRUN_COUNT_EN
    , input overrun_count
`endif
  );

  modport slave (
    input  line_render_start, line_idx,
    input  layer0_enabled, layer1_enabled, sprites_enabled,
    input  layer0_done, layer1_done, sprite_done,
    input  display_next_line, display_next_frame,
    output layer0_start, layer1_start, sprite_start,
    output render_line_idx, lb_wrsel, lb_rdsel, busy, overrun
`ifdef LINE_RENDER_OVERRUN_COUNT_EN
    , output overrun_count
`endif
  );
endinterface

// File: rtl/line_render_sequencer.sv
// Line render sequencer: runs the layer0, layer1 and sprite renderers
// serially (shared VRAM bus), then swaps line-buffer banks on the display
// line strobe. Late strobes or requests raise a one-cycle overrun pulse.
// Optional macro LINE_RENDER_OVERRUN_COUNT_EN adds a saturating 8-bit
// overrun counter on bus.overrun_count.
module line_render_sequencer (
  input  logic                   clk,
  input  logic                   rst_n,
  line_render_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    L0,
    L1,
    SPR,
    DONE
  } state_t;

  state_t     r_state;
  state_t     w_nxt;
  state_t     w_first;
  state_t     w_after_l0;
  state_t     w_after_l1;
  logic       w_ovr;
  logic       w_swap;
  logic       w_latch;
  logic       r_l0_start;
  logic       r_l1_start;
  logic       r_spr_start;
  logic       r_overrun;
  logic       r_rdsel;
  logic [8:0] r_line_idx;

  // Next enabled unit from each point in the L0 -> L1 -> SPR chain,
  // using the enables as they are right now.
  always_comb begin
    w_after_l1 = bus.sprites_enabled ? SPR : DONE;
    w_after_l0 = bus.layer1_enabled ? L1 : w_after_l1;
    w_first    = bus.layer0_enabled ? L0 : w_after_l0;
  end

  // Next state and event decode; display_next_frame overrides everything.
  always_comb begin
    w_nxt   = r_state;
    w_ovr   = 1'b0;
    w_swap  = 1'b0;
    w_latch = 1'b0;
    if (bus.display_next_frame) begin
      w_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.line_render_start) begin
            w_latch = 1'b1;
            w_nxt   = w_first;
          end
        end
        L0: begin
          w_ovr = bus.display_next_line | bus.line_render_start;
          if (bus.layer0_done) w_nxt = w_after_l0;
        end
        L1: begin
          w_ovr = bus.display_next_line | bus.line_render_start;
          if (bus.layer1_done) w_nxt = w_after_l1;
        end
        SPR: begin
          w_ovr = bus.display_next_line | bus.line_render_start;
          if (bus.sprite_done) w_nxt = DONE;
        end
        DONE: begin
          if (bus.display_next_line) begin
            w_swap = 1'b1;
            // A start arriving with the strobe begins the next line at once.
            if (bus.line_render_start) begin
              w_latch = 1'b1;
              w_nxt   = w_first;
            end else begin
              w_nxt = IDLE;
            end
          end else if (bus.line_render_start) begin
            w_ovr = 1'b1;
          end
        end
        default: w_nxt = IDLE;
      endcase
    end
  end

  // State register with registered start/overrun pulses and bank select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_l0_start  <= 1'b0;
      r_l1_start  <= 1'b0;
      r_spr_start <= 1'b0;
      r_overrun   <= 1'b0;
      r_rdsel     <= 1'b0;
      r_line_idx  <= '0;
    end else begin
      r_state     <= w_nxt;
      // A unit state is never re-entered from itself, so a state change
      // into it marks its first cycle.
      r_l0_start  <= (w_nxt == L0)  && (r_state != L0);
      r_l1_start  <= (w_nxt == L1)  && (r_state != L1);
      r_spr_start <= (w_nxt == SPR) && (r_state != SPR);
      r_overrun   <= w_ovr;
      if (w_swap)  r_rdsel    <= ~r_rdsel;
      if (w_latch) r_line_idx <= bus.line_idx;
    end
  end

  assign bus.layer0_start    = r_l0_start;
  assign bus.layer1_start    = r_l1_start;
  assign bus.sprite_start    = r_spr_start;
  assign bus.overrun         = r_overrun;
  assign bus.lb_rdsel        = r_rdsel;
  assign bus.lb_wrsel        = ~r_rdsel;
  assign bus.render_line_idx = r_line_idx;
  assign bus.busy            = (r_state != IDLE) && (r_state != DONE);

`ifdef LINE_RENDER_OVERRUN_COUNT_EN
  logic [7:0] r_ovr_cnt;

  // Saturating overrun counter, cleared at each frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr_cnt <= '0;
    end else if (bus.display_next_frame) begin
      r_ovr_cnt <= '0;
    end else if (w_ovr && (r_ovr_cnt != '1)) begin
      r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
  end

  assign bus.overrun_count = r_ovr_cnt;
`endif

endmodule

// File: tb/tb_line_render_sequencer.sv
// Bench for line_render_sequencer: directed line scenarios plus randomized
// traffic, every cycle compared against a unit-list reference model.
// Define LINE_RENDER_OVERRUN_COUNT_EN to also check overrun_count.
module tb_line_render_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  line_render_sequencer_if u_if ();

  line_render_sequencer u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the line is a list of units 0,1,2 (layer0, layer1,
  // sprites). A line is idle, running unit m_unit, or finished awaiting swap.
  localparam int MD_IDLE = 0;
  localparam int MD_RUN  = 1;
  localparam int MD_FIN  = 2;

  int         m_mode;
  int         m_unit;
  bit         m_rdsel;
  bit   [8:0] m_idx;
  bit   [2:0] m_start;
  bit         m_ov;
  int         m_cnt;
  bit   [2:0] en_vec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_unit(input int from, input bit [2:0] en);
    for (int u = from; u < 3; u++)
      if (en[u]) return u;
    return 3;
  endfunction

  task automatic launch(input int from, input bit [2:0] en);
    int u;
    u = next_unit(from, en);
    if (u == 3) begin
      m_mode = MD_FIN;
    end else begin
      m_mode     = MD_RUN;
      m_unit     = u;
      m_start[u] = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_mode  = MD_IDLE;
    m_unit  = 0;
    m_rdsel = 1'b0;
    m_idx   = '0;
    m_start = '0;
    m_ov    = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_edge();
    bit [2:0] en;
    bit [2:0] dn;
    bit       st;
    bit       nl;
    en = {u_if.sprites_enabled, u_if.layer1_enabled, u_if.layer0_enabled};
    dn = {u_if.sprite_done, u_if.layer1_done, u_if.layer0_done};
    st = u_if.line_render_start;
    nl = u_if.display_next_line;
    m_start = '0;
    m_ov    = 1'b0;
    if (u_if.display_next_frame) begin
      m_mode = MD_IDLE;
      m_cnt  = 0;
    end else if (m_mode == MD_IDLE) begin
      if (st) begin
        m_idx = u_if.line_idx;
        launch(0, en);
      end
    end else if (m_mode == MD_RUN) begin
      m_ov = nl || st;
      if (dn[m_unit]) launch(m_unit + 1, en);
    end else begin
      if (nl) begin
        m_rdsel = !m_rdsel;
        if (st) begin
          m_idx = u_if.line_idx;
          launch(0, en);
        end else begin
          m_mode = MD_IDLE;
        end
      end else if (st) begin
        m_ov = 1'b1;
      end
    end
    if (m_ov && m_cnt < 255) m_cnt++;
  endtask

  task automatic check_outputs();
    check("starts", {29'd0, u_if.sprite_start, u_if.layer1_start, u_if.layer0_start}, {29'd0, m_start});
    check("overrun", {31'd0, u_if.overrun}, {31'd0, m_ov});
    check("busy", {31'd0, u_if.busy}, {31'd0, m_mode == MD_RUN});
    check("lb_rdsel", {31'd0, u_if.lb_rdsel}, {31'd0, m_rdsel});
    check("lb_wrsel", {31'd0, u_if.lb_wrsel}, {31'd0, !m_rdsel});
    check("render_line_idx", {23'd0, u_if.render_line_idx}, {23'd0, m_idx});
`ifdef LINE_RENDER_OVERRUN_COUNT_EN
    check("overrun_count", {24'd0, u_if.overrun_count}, m_cnt);
`endif
  endtask

  task automatic set_en(input bit [2:0] en);
    en_vec = en;
    u_if.layer0_enabled  = en[0];
    u_if.layer1_enabled  = en[1];
    u_if.sprites_enabled = en[2];
  endtask

  // One clock: drive the cycle's inputs, let the edge happen, compare, clear pulses.
  task automatic step(input bit st, input bit [8:0] idx, input bit [2:0] dn, input bit nl, input bit fr);
    u_if.line_render_start  = st;
    u_if.line_idx           = idx;
    u_if.layer0_done        = dn[0];
    u_if.layer1_done        = dn[1];
    u_if.sprite_done        = dn[2];
    u_if.display_next_line  = nl;
    u_if.display_next_frame = fr;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    u_if.line_render_start  = 1'b0;
    u_if.layer0_done        = 1'b0;
    u_if.layer1_done        = 1'b0;
    u_if.sprite_done        = 1'b0;
    u_if.display_next_line  = 1'b0;
    u_if.display_next_frame = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 9'd0, 3'b000, 1'b0, 1'b0);
  endtask

  // Reset applied between edges; outputs must clear before any clock.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    u_if.line_render_start  = 1'b0;
    u_if.line_idx           = '0;
    u_if.layer0_done        = 1'b0;
    u_if.layer1_done        = 1'b0;
    u_if.sprite_done        = 1'b0;
    u_if.display_next_line  = 1'b0;
    u_if.display_next_frame = 1'b0;
    set_en(3'b111);
    model_reset();
    #3;
    check_outputs();
    #4 rst_n = 1'b1;

    // All units, done pulses 20 cycles apart, then swap
    step(1'b1, 9'd37, 3'b000, 1'b0, 1'b0);
    check("all_units_idx", {23'd0, u_if.render_line_idx}, 32'd37);
    idle(19);
    step(1'b0, 9'd0, 3'b001, 1'b0, 1'b0);
    idle(19);
    step(1'b0, 9'd0, 3'b010, 1'b0, 1'b0);
    idle(19);
    step(1'b0, 9'd0, 3'b100, 1'b0, 1'b0);
    check("all_units_busy_end", {31'd0, u_if.busy}, 32'd0);
    idle(2);
    step(1'b0, 9'd0, 3'b000, 1'b1, 1'b0);
    check("all_units_swap", {31'd0, u_if.lb_rdsel}, 32'd1);

    // Sprites only
    set_en(3'b100);
    step(1'b1, 9'd5, 3'b000, 1'b0, 1'b0);
    check("spr_only_start", {31'd0, u_if.sprite_start}, 32'd1);
    idle(3);
    step(1'b0, 9'd0, 3'b011, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b100, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b000, 1'b1, 1'b0);

    // Nothing enabled
    set_en(3'b000);
    step(1'b1, 9'd9, 3'b000, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b000, 1'b1, 1'b0);

    // Late line strobe in L1, line still completes, strobe in IDLE is a no-op
    set_en(3'b111);
    step(1'b1, 9'd100, 3'b000, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b001, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b000, 1'b1, 1'b0);
    check("l1_miss_overrun", {31'd0, u_if.overrun}, 32'd1);
    step(1'b0, 9'd0, 3'b010, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b100, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b000, 1'b1, 1'b0);
    step(1'b0, 9'd0, 3'b000, 1'b1, 1'b0);

    // Start with strobe in DONE; start in SPR ignored; done+strobe in SPR
    step(1'b1, 9'd200, 3'b000, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b001, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b010, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b100, 1'b0, 1'b0);
    step(1'b1, 9'd201, 3'b000, 1'b1, 1'b0);
    check("swap_start_l0", {31'd0, u_if.layer0_start}, 32'd1);
    step(1'b0, 9'd0, 3'b001, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b010, 1'b0, 1'b0);
    step(1'b1, 9'd300, 3'b000, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b100, 1'b1, 1'b0);
    step(1'b1, 9'd301, 3'b000, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b000, 1'b1, 1'b0);

    // Reset in SPR, then restart on the first edge after release
    step(1'b1, 9'd44, 3'b000, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b001, 1'b0, 1'b0);
    step(1'b0, 9'd0, 3'b010, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 9'd45, 3'b000, 1'b0, 1'b0);
    check("post_reset_start", {31'd0, u_if.layer0_start}, 32'd1);
    // Frame strobe in L0 with a competing done and line strobe
    step(1'b0, 9'd0, 3'b001, 1'b1, 1'b1);

    // Many overruns: saturation of the optional counter, then frame clear
    step(1'b1, 9'd1, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 9'd0, 3'b000, 1'b1, 1'b0);
    step(1'b0, 9'd0, 3'b000, 1'b0, 1'b1);

    // Randomized traffic, enables changing mid-line
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) set_en(3'($urandom_range(0, 7)));
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 7) == 0, 9'($urandom),
           {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0},
           $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
